// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone pipelined arbiter (Ibex instruction/data ports).
// Round-robin on contention, grant held until the master releases cyc and all responses return.
module wb_arbiter2 #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_stall,

  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_stall,

  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t     state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic [3:0] outst, outst_nxt;

  logic       gnt0, gnt1, granted;
  logic       full;
  logic       has_outst;
  logic       accept;
  logic       resp;
  logic       mux_cyc, mux_stb;

  assign gnt0      = (state == GNT0);
  assign gnt1      = (state == GNT1);
  assign granted   = gnt0 | gnt1;
  assign full      = (outst == MAX_CNT);
  assign has_outst = (outst != 4'd0);

  // Master 0 drives the shared slave fields whenever master 1 is not granted,
  // which keeps them at master-0 values while idle.
  assign mux_cyc = gnt1 ? m1_cyc   : m0_cyc;
  assign mux_stb = gnt1 ? m1_stb   : m0_stb;
  assign s_we    = gnt1 ? m1_we    : m0_we;
  assign s_sel   = gnt1 ? m1_sel   : m0_sel;
  assign s_adr   = gnt1 ? m1_adr   : m0_adr;
  assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;

  assign s_cyc = granted & mux_cyc;
  assign s_stb = granted & mux_stb & ~full;

  assign accept = s_stb & ~s_stall;
  // A response with nothing outstanding is stray: it is neither counted nor forwarded.
  assign resp   = (s_ack | s_err) & has_outst;

  assign m0_ack   = gnt0 & s_ack & has_outst;
  assign m0_err   = gnt0 & s_err & has_outst;
  assign m1_ack   = gnt1 & s_ack & has_outst;
  assign m1_err   = gnt1 & s_err & has_outst;
  assign m0_stall = gnt0 ? (s_stall | full) : 1'b1;
  assign m1_stall = gnt1 ? (s_stall | full) : 1'b1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    outst_nxt = outst;
    unique case ({accept, resp})
      2'b10:   outst_nxt = outst + 4'd1;
      2'b01:   outst_nxt = outst - 4'd1;
      default: outst_nxt = outst;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    unique case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          if (last_gnt) begin
            state_nxt    = GNT0;
            last_gnt_nxt = 1'b0;
          end else begin
            state_nxt    = GNT1;
            last_gnt_nxt = 1'b1;
          end
        end else if (m0_cyc) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (m1_cyc) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0: if (!m0_cyc && outst_nxt == 4'd0) state_nxt = IDLE;
      GNT1: if (!m1_cyc && outst_nxt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      outst    <= 4'd0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      outst    <= outst_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: grant, round-robin, outstanding limit, hold-on-release,
// asynchronous reset and error routing.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat_i, m0_dat_o;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat_i, m1_dat_o;
  logic        m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_ack, s_err, s_stall;

  int checks   = 0;
  int failures = 0;

  wb_arbiter2 #(.MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 0; m0_dat_i = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h3; m1_adr = 0; m1_dat_i = 0;
    s_dat_i = 0; s_ack = 0; s_err = 0; s_stall = 0;
    tick();
    tick();

    // Reset state, with a requesting master and slave responses present.
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_err = 1;
    #1;
    check("rst_s_cyc",    32'(s_cyc),    32'd0);
    check("rst_s_stb",    32'(s_stb),    32'd0);
    check("rst_m0_stall", 32'(m0_stall), 32'd1);
    check("rst_m1_stall", 32'(m1_stall), 32'd1);
    check("rst_m0_ack",   32'(m0_ack),   32'd0);
    check("rst_m0_err",   32'(m0_err),   32'd0);
    check("rst_outst",    32'(dut.outst), 32'd0);
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_err = 0;
    tick();
    rst = 1'b0;

    // Single m0 read at 0x100.
    m0_adr = 32'h100; m0_cyc = 1; m0_stb = 1;
    #1;
    check("rd_idle_stall", 32'(m0_stall), 32'd1);
    check("rd_idle_s_cyc", 32'(s_cyc),    32'd0);
    tick();
    check("rd_gnt_stall",  32'(m0_stall), 32'd0);
    check("rd_gnt_s_stb",  32'(s_stb),    32'd1);
    check("rd_gnt_s_adr",  s_adr,         32'h100);
    check("rd_gnt_m1stall", 32'(m1_stall), 32'd1);
    tick();
    m0_stb = 0; s_ack = 1; s_dat_i = 32'hDEADBEEF;
    #1;
    check("rd_ack",    32'(m0_ack),    32'd1);
    check("rd_dat",    m0_dat_o,       32'hDEADBEEF);
    check("rd_outst1", 32'(dut.outst), 32'd1);
    tick();
    s_ack = 0; m0_cyc = 0;
    #1;
    check("rd_ack_pulse", 32'(m0_ack), 32'd0);
    tick();
    check("rd_outst0",   32'(dut.outst), 32'd0);
    check("rd_idle_end", 32'(m0_stall),  32'd1);
    check("rd_s_cyc_end", 32'(s_cyc),    32'd0);

    // Simultaneous contention after reset: m0 first, then m1, then m0 again.
    rst = 1;
    tick();
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    m1_adr = 32'h200; m1_we = 1; m1_dat_i = 32'hCAFE0001;
    #1;
    check("arb_idle_m0_stall", 32'(m0_stall), 32'd1);
    check("arb_idle_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    check("arb_g0_m0_stall", 32'(m0_stall), 32'd0);
    check("arb_g0_m1_stall", 32'(m1_stall), 32'd1);
    check("arb_g0_s_adr",    s_adr,         32'h100);
    check("arb_g0_s_we",     32'(s_we),     32'd0);
    tick();
    m0_stb = 0; s_ack = 1;
    #1;
    check("arb_g0_m0_ack", 32'(m0_ack), 32'd1);
    check("arb_g0_m1_ack", 32'(m1_ack), 32'd0);
    tick();
    s_ack = 0; m0_cyc = 0;
    #1;
    check("arb_g0_rel_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    check("arb_idle2_m1_stall", 32'(m1_stall), 32'd1);
    check("arb_idle2_s_cyc",    32'(s_cyc),    32'd0);
    check("arb_idle2_s_adr",    s_adr,         32'h100);
    tick();
    check("arb_g1_m1_stall", 32'(m1_stall), 32'd0);
    check("arb_g1_s_adr",    s_adr,         32'h200);
    check("arb_g1_s_we",     32'(s_we),     32'd1);
    check("arb_g1_s_dat",    s_dat_o,       32'hCAFE0001);
    tick();
    m1_stb = 0; s_ack = 1;
    #1;
    check("arb_g1_m1_ack", 32'(m1_ack), 32'd1);
    check("arb_g1_m0_ack", 32'(m0_ack), 32'd0);
    tick();
    s_ack = 0; m1_cyc = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    check("arb_rr_m0_stall", 32'(m0_stall), 32'd0);
    check("arb_rr_m1_stall", 32'(m1_stall), 32'd1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // Outstanding limit: m1 streams strobes, slave withholds acks for 10 cycles.
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h300;
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("lim_outst_c%0d", k), 32'(dut.outst), (k < 4) ? 32'(k) : 32'd4);
      check($sformatf("lim_stall_c%0d", k), 32'(m1_stall), (k >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    s_ack = 1;
    #1;
    check("lim_first_ack",   32'(m1_ack),   32'd1);
    check("lim_ack_stalled", 32'(m1_stall), 32'd1);
    tick();
    s_ack = 0;
    #1;
    check("lim_resume_stall", 32'(m1_stall),  32'd0);
    check("lim_resume_outst", 32'(dut.outst), 32'd3);
    tick();
    #1;
    check("lim_refull_outst", 32'(dut.outst), 32'd4);
    check("lim_refull_stall", 32'(m1_stall),  32'd1);
    s_ack = 1;
    tick();
    #1;
    check("lim_both_pre",   32'(dut.outst), 32'd3);
    check("lim_both_stall", 32'(m1_stall),  32'd0);
    tick();
    #1;
    check("lim_both_same", 32'(dut.outst), 32'd3);
    m1_stb = 0;
    tick();
    tick();
    m1_cyc = 0;
    tick();
    s_ack = 0;
    #1;
    check("lim_end_outst", 32'(dut.outst), 32'd0);
    check("lim_end_stall", 32'(m1_stall),  32'd1);
    check("lim_end_ack",   32'(m1_ack),    32'd0);

    // m0 releases cyc with two responses pending while m1 waits.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
    tick();
    check("hold_g0_m0_stall", 32'(m0_stall), 32'd0);
    check("hold_g0_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    tick();
    m0_cyc = 0; m0_stb = 0;
    #1;
    check("hold_outst2", 32'(dut.outst), 32'd2);
    tick();
    check("hold_still_g0", 32'(m1_stall), 32'd1);
    s_ack = 1; s_dat_i = 32'h11111111;
    #1;
    check("hold_ack1_m0", 32'(m0_ack), 32'd1);
    check("hold_ack1_m1", 32'(m1_ack), 32'd0);
    check("hold_dat_m0",  m0_dat_o,    32'h11111111);
    tick();
    check("hold_ack2_m0",  32'(m0_ack),   32'd1);
    check("hold_ack2_stl", 32'(m1_stall), 32'd1);
    tick();
    s_ack = 0;
    #1;
    check("hold_idle_m1_stall", 32'(m1_stall),  32'd1);
    check("hold_idle_outst",    32'(dut.outst), 32'd0);
    tick();
    check("hold_g1_m1_stall", 32'(m1_stall), 32'd0);
    check("hold_g1_s_adr",    s_adr,         32'h500);

    // Asynchronous reset mid-transaction with three pending, then a late ack.
    tick();
    tick();
    tick();
    check("rst_mid_outst3", 32'(dut.outst), 32'd3);
    rst = 1;
    #1;
    check("rst_mid_s_cyc",    32'(s_cyc),     32'd0);
    check("rst_mid_outst",    32'(dut.outst), 32'd0);
    check("rst_mid_m1_stall", 32'(m1_stall),  32'd1);
    tick();
    rst = 0; m1_stb = 0; s_ack = 1;
    #1;
    check("late_ack_idle", 32'(m1_ack), 32'd0);
    tick();
    check("late_ack_gnt",   32'(m1_ack),   32'd0);
    check("late_ack_stall", 32'(m1_stall), 32'd0);
    tick();
    check("late_ack_outst", 32'(dut.outst), 32'd0);
    s_ack = 0;

    // Error on the second of two m1 requests.
    m1_stb = 1;
    tick();
    tick();
    m1_stb = 0; s_ack = 1;
    #1;
    check("err_first_ack",  32'(m1_ack),    32'd1);
    check("err_first_err",  32'(m1_err),    32'd0);
    check("err_outst2",     32'(dut.outst), 32'd2);
    tick();
    s_ack = 0; s_err = 1; m1_cyc = 0;
    #1;
    check("err_second_err", 32'(m1_err), 32'd1);
    check("err_second_ack", 32'(m1_ack), 32'd0);
    check("err_m0_err",     32'(m0_err), 32'd0);
    tick();
    s_err = 0;
    #1;
    check("err_pulse_once", 32'(m1_err),    32'd0);
    check("err_outst0",     32'(dut.outst), 32'd0);
    check("err_idle_s_cyc", 32'(s_cyc),     32'd0);
    check("err_idle_stall", 32'(m1_stall),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
